// File: rtl/mem_port_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the single-port SRAM.
// The master modport is the arbiter's view; the slave modport is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  p0_req;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic                  p0_we;
  logic [BE_W-1:0]       p0_be;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic                  p1_we;
  logic [BE_W-1:0]       p1_be;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [BE_W-1:0]       mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  p0_req, p0_addr, p0_we, p0_be, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_addr, p1_we, p1_be, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_en, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output p0_req, p0_addr, p0_we, p0_be, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_addr, p1_we, p1_be, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_en, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter onto one single-port SRAM: fixed priority to port 0 with a port-1 starvation guard.
// Optional grant/conflict statistics counters are enabled by defining ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.master   bus
`ifdef ARB_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [31:0]          stat_p0_cnt,
  output logic [31:0]          stat_p1_cnt,
  output logic [31:0]          stat_conflict_cnt
`endif
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic             run_q;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             resp_valid_q, resp_port_q, resp_we_q;
  logic             force1, gnt0, gnt1;

  always_comb begin
    force1 = bus.p1_req && (wait_cnt_q == MAX_CNT);
    gnt1   = run_q && (force1 || (bus.p1_req && !bus.p0_req));
    gnt0   = run_q && !gnt1 && bus.p0_req;
  end

  assign bus.p0_gnt = gnt0;
  assign bus.p1_gnt = gnt1;
  assign bus.mem_en = gnt0 | gnt1;

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    if (gnt1) begin
      bus.mem_addr  = bus.p1_addr;
      bus.mem_we    = bus.p1_we;
      bus.mem_be    = bus.p1_be;
      bus.mem_wdata = bus.p1_wdata;
    end else if (gnt0) begin
      bus.mem_addr  = bus.p0_addr;
      bus.mem_we    = bus.p0_we;
      bus.mem_be    = bus.p0_be;
      bus.mem_wdata = bus.p0_wdata;
    end
  end

  // Never exceeds MAX_CNT: at MAX_CNT a waiting port 1 is force-granted, which clears it.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (gnt1 || !bus.p1_req)
      wait_cnt_d = '0;
    else if (wait_cnt_q != MAX_CNT)
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      wait_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_port_q  <= 1'b0;
      resp_we_q    <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      wait_cnt_q   <= wait_cnt_d;
      resp_valid_q <= bus.mem_en;
      resp_port_q  <= gnt1;
      resp_we_q    <= bus.mem_we;
    end
  end

  // Memory read data is steered to the port that owned the previous cycle's access.
  assign bus.p0_rvalid = resp_valid_q && !resp_port_q;
  assign bus.p1_rvalid = resp_valid_q &&  resp_port_q;
  assign bus.p0_rdata  = (bus.p0_rvalid && !resp_we_q) ? bus.mem_rdata : '0;
  assign bus.p1_rdata  = (bus.p1_rvalid && !resp_we_q) ? bus.mem_rdata : '0;

`ifdef ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] p0_cnt_q, p1_cnt_q, conf_cnt_q;
  logic [31:0] p0_cnt_d, p1_cnt_d, conf_cnt_d;

  always_comb begin
    p0_cnt_d   = gnt0 ? sat_inc(p0_cnt_q) : p0_cnt_q;
    p1_cnt_d   = gnt1 ? sat_inc(p1_cnt_q) : p1_cnt_q;
    conf_cnt_d = (bus.p0_req && bus.p1_req && run_q) ? sat_inc(conf_cnt_q) : conf_cnt_q;
    if (stat_clr) begin
      p0_cnt_d   = '0;
      p1_cnt_d   = '0;
      conf_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_cnt_q   <= '0;
      p1_cnt_q   <= '0;
      conf_cnt_q <= '0;
    end else begin
      p0_cnt_q   <= p0_cnt_d;
      p1_cnt_q   <= p1_cnt_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end

  assign stat_p0_cnt       = p0_cnt_q;
  assign stat_p1_cnt       = p1_cnt_q;
  assign stat_conflict_cnt = conf_cnt_q;
`endif

endmodule
